svc_rv_io_uart_tx: RTL and testbench

- Memory-mapped I/O responder that sits on the SoC MMIO bus (io_raddr/io_rdata, io_wen/io_waddr/io_wdata/io_wstrb) in place of a plain I/O SRAM.
- Receives CPU stores into a TX FIFO and serializes the bytes as 8N1 UART frames.
- Answers CPU loads from its status and config registers with the same 1-cycle registered read latency as svc_mem_sram, so the core's load path is unchanged.

---
 rtl/svc_rv_io_uart_tx.sv | 155 +++++++++++++++
 tb/tb_svc_rv_io_uart_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/svc_rv_io_uart_tx.sv
// svc_rv_io_uart_tx: MMIO TX FIFO + 8N1 UART serializer; SVC_RV_IO_UART_TX_DISPLAY_EN echoes pushed bytes to the sim console
module svc_rv_io_uart_tx #(
   parameter int AW         = 10,
   parameter int FIFO_AW    = 4,
   parameter int CLKDIV_RST = 867
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] io_raddr,
   output logic [31:0] io_rdata,
   input  logic        io_wen,
   input  logic [31:0] io_waddr,
   input  logic [31:0] io_wdata,
   input  logic [3:0]  io_wstrb,
   output logic        txd,
   output logic        irq_empty
);
   localparam int CW = FIFO_AW + 1;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t              state, state_nxt;
   logic [7:0]          mem [2**FIFO_AW];
   logic [FIFO_AW-1:0]  wptr, rptr;
   logic [FIFO_AW:0]    count;
   logic [15:0]         clkdiv, div_q, timer;
   logic [31:0]         scratch, status, rd_val;
   logic [7:0]          shift;
   logic [2:0]          bitcnt;
   logic [1:0]          w_idx, r_idx;
   logic                overflow, full, empty, pop, push_req, push, ovf_clr, w_hit, timer_done;
   logic                unused;

   function automatic logic hit(input logic [31:0] a);
      return a[31:AW] == '0 && a[AW-1:4] == '0;
   endfunction

   assign unused     = &{1'b0, io_raddr[1:0], io_waddr[1:0]};
   assign w_idx      = io_waddr[3:2];
   assign r_idx      = io_raddr[3:2];
   assign full       = count[FIFO_AW];
   assign empty      = count == '0;
   assign w_hit      = io_wen && hit(io_waddr);
   assign push_req   = w_hit && w_idx == 2'd0 && io_wstrb[0];
   assign push       = push_req && (!full || pop);
   assign ovf_clr    = w_hit && w_idx == 2'd1 && io_wstrb[0] && io_wdata[3];
   assign timer_done = timer == '0;
   assign status     = 32'({count, 4'b0, overflow, state != IDLE, empty, full});
   assign rd_val     = !hit(io_raddr) ? '0 :
                       r_idx == 2'd1  ? status :
                       r_idx == 2'd2  ? {16'b0, clkdiv} :
                       r_idx == 2'd3  ? scratch : '0;

   // Registered read port with no enable: one-cycle load latency, reads see pre-write values
   always_ff @(posedge clk) begin
      if (!rst_n) io_rdata <= '0;
      else        io_rdata <= rd_val;
   end

   // Byte-strobed config and scratch registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clkdiv  <= 16'(CLKDIV_RST);
         scratch <= '0;
      end else begin
         for (int i = 0; i < 2; i++) if (w_hit && w_idx == 2'd2 && io_wstrb[i]) clkdiv[8*i+:8] <= io_wdata[8*i+:8];
         for (int i = 0; i < 4; i++) if (w_hit && w_idx == 2'd3 && io_wstrb[i]) scratch[8*i+:8] <= io_wdata[8*i+:8];
      end
   end

   // FIFO storage; a push into a full FIFO only lands when the same-cycle pop frees the slot
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= io_wdata[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow (a new drop wins over a same-cycle clear)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wptr <= wptr + FIFO_AW'(1);
         if (pop)  rptr <= rptr + FIFO_AW'(1);
         count    <= count + CW'(push) - CW'(pop);
         overflow <= (overflow && !ovf_clr) || (push_req && !push);
      end
   end

   // Serializer state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state, FIFO pop and line level; every state lasts div_q+1 clocks
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      txd       = 1'b1;
      case (state)
         IDLE: begin
            pop       = !empty;
            state_nxt = empty ? IDLE : START;
         end
         START: begin
            txd       = 1'b0;
            state_nxt = timer_done ? DATA : START;
         end
         DATA: begin
            txd       = shift[0];
            state_nxt = timer_done && bitcnt == 3'd7 ? STOP : DATA;
         end
         STOP:    state_nxt = timer_done ? IDLE : STOP;
         default: state_nxt = IDLE;
      endcase
   end

   // Bit timer, shift register and bit counter; the divisor is frozen per frame at pop time
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer  <= '0;
         div_q  <= '0;
         shift  <= '0;
         bitcnt <= '0;
      end else if (pop) begin
         timer  <= clkdiv;
         div_q  <= clkdiv;
         shift  <= mem[rptr];
         bitcnt <= '0;
      end else if (state != IDLE) begin
         timer <= timer_done ? div_q : timer - 16'd1;
         if (state == DATA && timer_done) begin
            shift  <= shift >> 1;
            bitcnt <= bitcnt + 3'd1;
         end
      end
   end

   // Interrupt: FIFO drained and serializer idle, as of the previous edge
   always_ff @(posedge clk) begin
      if (!rst_n) irq_empty <= 1'b1;
      else        irq_empty <= empty && state == IDLE;
   end

`ifdef SVC_RV_IO_UART_TX_DISPLAY_EN
`ifndef SYNTHESIS
   // Echo each accepted byte to the simulation console as it enters the FIFO
   always_ff @(posedge clk) begin
      if (rst_n && push) $write("%c", io_wdata[7:0]);
   end
`endif
`else
`endif

endmodule

// File: tb/tb_svc_rv_io_uart_tx.sv
// tb_svc_rv_io_uart_tx: scoreboard bench with a transaction-level model of the UART TX responder
module tb_svc_rv_io_uart_tx;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] io_raddr, io_rdata, io_waddr, io_wdata;
   logic        io_wen, txd, irq_empty;
   logic [3:0]  io_wstrb;
   logic        rd_chk;
   string       rd_name;

   typedef struct {logic [7:0] b; int d;} fr_t;

   int          tests = 0, fails = 0;
   logic [7:0]  mq[$];
   fr_t         tx_q[$];
   logic [31:0] rd_q[$];
   string       rn_q[$];
   int          t, t_free;
   logic        m_ovf, m_irq, m_valid, rd_pend, kill;
   logic [15:0] m_div;
   logic [31:0] m_scr;
   logic [31:0] ra_tab[7] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h404, 32'h8000_0008};

   svc_rv_io_uart_tx dut (
      .clk(clk), .rst_n(rst_n), .io_raddr(io_raddr), .io_rdata(io_rdata),
      .io_wen(io_wen), .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wstrb(io_wstrb),
      .txd(txd), .irq_empty(irq_empty)
   );

   always #5 clk = ~clk;

   // Reference model: FIFO as a queue, serializer as "busy until cycle t_free"
   initial begin
      int   sz;
      logic idle, pop, hw, preq, acc;
      logic [1:0] wi, ri;
      logic [31:0] rexp;
      fr_t  fr;
      t = 0; t_free = 0; m_valid = 0; rd_pend = 0; kill = 0; m_irq = 1; m_ovf = 0; m_div = 16'd867; m_scr = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            mq.delete(); tx_q.delete();
            m_ovf = 0; m_div = 16'd867; m_scr = 0; t_free = t; m_irq = 1; m_valid = 1; kill = 1; rd_pend = 0;
         end else if (m_valid) begin
            sz = mq.size();
            idle = t >= t_free;
            ri = io_raddr[3:2];
            wi = io_waddr[3:2];
            rexp = io_raddr[31:4] != 0 ? 32'h0 :
                   ri == 2'd1 ? {19'b0, 5'(sz), 4'b0, m_ovf, !idle, sz == 0, sz == 16} :
                   ri == 2'd2 ? {16'b0, m_div} :
                   ri == 2'd3 ? m_scr : 32'h0;
            rd_pend = rd_chk;
            if (rd_chk) begin rd_q.push_back(rexp); rn_q.push_back(rd_name); end
            m_irq = sz == 0 && idle;
            pop = idle && sz > 0;
            hw = io_wen && io_waddr[31:4] == 0;
            preq = hw && wi == 2'd0 && io_wstrb[0];
            acc = preq && (sz < 16 || pop);
            if (pop) begin
               fr.b = mq.pop_front();
               fr.d = int'(m_div);
               tx_q.push_back(fr);
               t_free = t + 10 * (int'(m_div) + 1) + 1;
            end
            if (acc) mq.push_back(io_wdata[7:0]);
            m_ovf = (m_ovf && !(hw && wi == 2'd1 && io_wstrb[0] && io_wdata[3])) || (preq && !acc);
            for (int i = 0; i < 2; i++) if (hw && wi == 2'd2 && io_wstrb[i]) m_div[8*i+:8] = io_wdata[8*i+:8];
            for (int i = 0; i < 4; i++) if (hw && wi == 2'd3 && io_wstrb[i]) m_scr[8*i+:8] = io_wdata[8*i+:8];
         end
         t++;
      end
   end

   // Read monitor: one registered read result per issued read
   initial forever begin
      @(negedge clk);
      if (rd_pend && rd_q.size() > 0) begin
         logic [31:0] e;
         string nm;
         e = rd_q.pop_front();
         nm = rn_q.pop_front();
         tests++;
         if (io_rdata !== e) begin
            fails++;
            $display("FAIL %s io_rdata=%h expected=%h", nm, io_rdata, e);
         end
      end
   end

   // irq monitor
   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         tests++;
         if (irq_empty !== m_irq) begin
            fails++;
            $display("FAIL irq_empty at cycle %0d got=%b expected=%b", t, irq_empty, m_irq);
         end
      end
   end

   // Frame monitor: every cycle of each bit slot must carry the expected level
   initial forever begin
      @(negedge clk);
      if (m_valid && rst_n && txd === 1'b0) begin
         kill = 0;
         if (tx_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL frame_unexpected start bit seen with no byte expected");
         end else begin
            fr_t e;
            logic [9:0] ex, got;
            logic bad, ab;
            e = tx_q.pop_front();
            ex = {1'b1, e.b, 1'b0};
            got = '0; bad = 0; ab = 0;
            for (int s = 0; s < 10 && !ab; s++)
               for (int c = 0; c <= e.d && !ab; c++) begin
                  if (s != 0 || c != 0) @(negedge clk);
                  if (kill) ab = 1;
                  else begin
                     if (txd !== ex[s]) bad = 1;
                     if (c == 0) got[s] = txd;
                  end
               end
            if (!ab) begin
               tests++;
               if (bad) begin
                  fails++;
                  $display("FAIL frame got=%h bits=%b expected=%h div=%0d", got[8:1], got, e.b, e.d);
               end
            end
         end
      end
   end

   task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                        input logic rc, input logic [31:0] ra, input string nm);
      @(negedge clk);
      io_wen = we; io_waddr = wa; io_wdata = wd; io_wstrb = ws; rd_chk = rc; io_raddr = ra; rd_name = nm;
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      drive(1'b1, a, d, s, 1'b0, 32'h0, "");
   endtask
   task automatic rd(input logic [31:0] a, input string nm);
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, a, nm);
   endtask
   task automatic nop();
      drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, "");
   endtask
   task automatic chk1(input string nm, input logic act, input logic exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s got=%b expected=%b", nm, act, exp_v);
      end
   endtask
   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (!(mq.size() == 0 && t >= t_free) && n < 5000) begin nop(); n++; end
      repeat (3) nop();
      tests++;
      if (n >= 5000) begin
         fails++;
         $display("FAIL %s timeout pending=%0d expected=0", nm, mq.size());
      end
   endtask

   initial begin
      logic quiet;
      rst_n = 0; io_wen = 0; io_waddr = 0; io_wdata = 0; io_wstrb = 0; io_raddr = 0; rd_chk = 0; rd_name = "";
      repeat (3) @(negedge clk);
      rst_n = 1;
      chk1("rst_txd", txd, 1'b1);
      chk1("rst_irq", irq_empty, 1'b1);
      rd(32'h4, "rst_status"); rd(32'h8, "rst_clkdiv"); rd(32'h0, "rst_txdata"); rd(32'hC, "rst_scratch"); nop();
      wr(32'h8, 32'd3, 4'b0011); wr(32'h0, 32'h55, 4'b0001); nop(); nop(); rd(32'h4, "busy_status"); nop();
      wait_idle("frame_55");
      rd(32'h4, "idle_status"); nop();
      wr(32'hC, 32'hDEAD_BEEF, 4'hF); wr(32'hC, 32'h0, 4'b0101); rd(32'hC, "scratch_strb");
      wr(32'h0, 32'h77, 4'b1110); rd(32'h4, "no_push_status");
      drive(1'b1, 32'hC, 32'h1234_5678, 4'hF, 1'b1, 32'hC, "scratch_rw_same"); rd(32'hC, "scratch_new"); nop();
      wr(32'h8, 32'd3, 4'b0011);
      for (int i = 0; i < 18; i++) wr(32'h0, 32'h41 + i, 4'b0001);
      rd(32'h4, "ovf_status"); wr(32'h4, 32'h8, 4'b0001); rd(32'h4, "ovf_cleared"); nop();
      wait_idle("ovf_drain");
      wr(32'h8, 32'd0, 4'b0011);
      for (int i = 0; i < 30; i++) drive(1'b1, 32'h0, 32'h60 + i, 4'b0001, 1'b1, 32'h4, "full_pp_status");
      nop();
      wait_idle("full_pp_drain");
      for (int k = 0; k < 300; k++) begin
         int r;
         logic [31:0] ra;
         r = $urandom_range(0, 9);
         ra = ra_tab[$urandom_range(0, 6)];
         case (r)
            0, 1, 2, 3: drive(1'b1, 32'h0, $urandom, 4'($urandom), 1'b1, ra, "rand_rd");
            4:          drive(1'b1, 32'h8, $urandom_range(0, 3), {2'($urandom), 2'b11}, 1'b1, ra, "rand_rd");
            5:          drive(1'b1, 32'hC, $urandom, 4'($urandom), 1'b1, ra, "rand_rd");
            6:          drive(1'b1, 32'h4, $urandom, 4'($urandom), 1'b1, ra, "rand_rd");
            7:          drive(1'b1, ra_tab[4 + $urandom_range(0, 2)], $urandom, 4'hF, 1'b1, ra, "rand_rd");
            default:    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, ra, "rand_rd");
         endcase
      end
      nop();
      wait_idle("rand_drain");
      wr(32'h8, 32'd3, 4'b0011); wr(32'h0, 32'hA5, 4'b0001); wr(32'h0, 32'h11, 4'b0001); wr(32'h0, 32'h22, 4'b0001);
      repeat (10) nop();
      @(negedge clk); rst_n = 0;
      @(negedge clk); rst_n = 1;
      chk1("rst_mid_txd", txd, 1'b1);
      rd(32'h4, "rst_mid_status"); rd(32'h8, "rst_mid_clkdiv"); nop();
      quiet = 1;
      repeat (200) begin @(negedge clk); if (txd !== 1'b1) quiet = 0; end
      chk1("rst_mid_no_resume", quiet, 1'b1);
      tests++;
      if (tx_q.size() != 0 || rd_q.size() != 0) begin
         fails++;
         $display("FAIL leftover frames=%0d reads=%0d expected=0", tx_q.size(), rd_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
